// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: the FSM state type.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Tick-driven down-counter with one-shot or periodic expiry, pause/resume
// and an acknowledged done level. All outputs are registered.
module countdown_timer #(
   parameter int unsigned WIDTH       = 16,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             expired
);

   import timer_pkg::*;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state, state_n;
   logic [WIDTH-1:0] reload, reload_n, count_n;
   logic             expired_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         reload  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         reload  <= reload_n;
         busy    <= (state_n == RUN);
         done    <= (state_n == DONE);
         expired <= expired_n;
      end
   end

   // Priority load > stop > start > ack > tick; a command only pre-empts
   // lower ones in states where it has a defined meaning.
   always_comb begin
      state_n   = state;
      count_n   = count;
      reload_n  = reload;
      expired_n = 1'b0;
      if (load) begin
         reload_n = load_val;
         count_n  = load_val;
         state_n  = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  if (count != '0) begin
                     state_n = RUN;
                  end else begin
                     state_n   = DONE;
                     expired_n = 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state_n = PAUSE;
               end else if (tick) begin
                  if (count > ONE) begin
                     count_n = count - ONE;
                  end else if (count == ONE) begin
                     expired_n = 1'b1;
                     if (AUTO_RELOAD && (reload != '0)) begin
                        count_n = reload;
                     end else begin
                        count_n = '0;
                        state_n = DONE;
                     end
                  end
               end
            end
            PAUSE: begin
               if (!stop) begin
                  if (start) begin
                     state_n = RUN;
                  end else if (ack) begin
                     state_n = IDLE;
                  end
               end
            end
            DONE: begin
               if (ack) begin
                  state_n = IDLE;
                  count_n = reload;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one-shot and periodic instances driven in lockstep,
// directed scenarios plus random traffic checked against a rule-level model.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst, tick, load, start, stop, ack;
   logic [15:0] load_val;
   logic [15:0] count0, count1;
   logic        busy0, busy1, done0, done1, exp0, exp1;

   int n_assert = 0;
   int n_fail   = 0;

   // model state per instance: index 0 one-shot, index 1 periodic
   string m_mode[2];
   int    m_cnt[2];
   int    m_rl[2];
   bit    m_exp[2];

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .ack(ack),
      .count(count0), .busy(busy0), .done(done0), .expired(exp0)
   );

   countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .ack(ack),
      .count(count1), .busy(busy1), .done(done1), .expired(exp1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_step(input int k);
      m_exp[k] = 1'b0;
      if (rst) begin
         m_mode[k] = "idle"; m_cnt[k] = 0; m_rl[k] = 0;
      end else if (load) begin
         m_rl[k] = int'(load_val); m_cnt[k] = int'(load_val); m_mode[k] = "idle";
      end else if (m_mode[k] == "idle") begin
         if (start && !stop) begin
            if (m_cnt[k] != 0) m_mode[k] = "run";
            else begin m_mode[k] = "done"; m_exp[k] = 1'b1; end
         end
      end else if (m_mode[k] == "run") begin
         if (stop) m_mode[k] = "pause";
         else if (tick && m_cnt[k] > 1) m_cnt[k] = m_cnt[k] - 1;
         else if (tick && m_cnt[k] == 1) begin
            m_exp[k] = 1'b1;
            if (k == 1 && m_rl[k] != 0) m_cnt[k] = m_rl[k];
            else begin m_cnt[k] = 0; m_mode[k] = "done"; end
         end
      end else if (m_mode[k] == "pause") begin
         if (!stop && start) m_mode[k] = "run";
         else if (!stop && ack) m_mode[k] = "idle";
      end else if (m_mode[k] == "done") begin
         if (ack) begin m_mode[k] = "idle"; m_cnt[k] = m_rl[k]; end
      end
   endtask

   // one clock: DUT and model both consume the current inputs, then compare
   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk("m0_count",   32'(count0), 32'(m_cnt[0]));
      chk("m0_busy",    32'(busy0),  32'(m_mode[0] == "run"));
      chk("m0_done",    32'(done0),  32'(m_mode[0] == "done"));
      chk("m0_expired", 32'(exp0),   32'(m_exp[0]));
      chk("m1_count",   32'(count1), 32'(m_cnt[1]));
      chk("m1_busy",    32'(busy1),  32'(m_mode[1] == "run"));
      chk("m1_done",    32'(done1),  32'(m_mode[1] == "done"));
      chk("m1_expired", 32'(exp1),   32'(m_exp[1]));
      rst = 0; tick = 0; load = 0; start = 0; stop = 0; ack = 0;
   endtask

   task automatic do_idle();         cycle(); endtask
   task automatic do_rst();          rst = 1; cycle(); endtask
   task automatic do_load(input int v); load = 1; load_val = 16'(v); cycle(); endtask
   task automatic do_start();        start = 1; cycle(); endtask
   task automatic do_tick();         tick = 1; cycle(); endtask
   task automatic do_ack();          ack = 1; cycle(); endtask

   initial begin
      int ne;
      rst = 0; tick = 0; load = 0; start = 0; stop = 0; ack = 0; load_val = '0;
      m_mode[0] = "idle"; m_mode[1] = "idle";
      m_cnt = '{0, 0}; m_rl = '{0, 0}; m_exp = '{1'b0, 1'b0};

      do_rst(); do_rst();
      chk("rst_count", 32'(count0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_done", 32'(done0), 0);
      chk("rst_expired", 32'(exp0), 0);

      // one-shot 3,2,1,0
      do_load(3);
      chk("os_load_count", 32'(count0), 3);
      do_start();
      chk("os_start_busy", 32'(busy0), 1);
      ne = 0;
      do_tick(); chk("os_t1", 32'(count0), 2); ne += int'(exp0);
      do_tick(); chk("os_t2", 32'(count0), 1); ne += int'(exp0);
      do_tick(); chk("os_t3", 32'(count0), 0); ne += int'(exp0);
      chk("os_exp_on_t3", 32'(exp0), 1);
      chk("os_exp_pulses", 32'(ne), 1);
      chk("os_done", 32'(done0), 1);
      chk("os_busy", 32'(busy0), 0);
      do_idle();
      chk("os_exp_cleared", 32'(exp0), 0);

      // periodic 2,1,2,1,2,1,2
      do_load(2); do_start();
      chk("per_start", 32'(count1), 2);
      ne = 0;
      for (int i = 0; i < 6; i++) begin
         do_tick();
         chk("per_count", 32'(count1), (i % 2 == 0) ? 1 : 2);
         ne += int'(exp1);
      end
      chk("per_exp_pulses", 32'(ne), 3);
      chk("per_done", 32'(done1), 0);
      chk("per_busy", 32'(busy1), 1);

      // pause with a discarded tick
      do_load(5); do_start(); do_tick(); do_tick();
      chk("pz_before", 32'(count0), 3);
      ne = 0;
      stop = 1; tick = 1; cycle();
      chk("pz_stop_tick", 32'(count0), 3);
      chk("pz_busy", 32'(busy0), 0);
      for (int i = 0; i < 3; i++) begin
         do_tick(); chk("pz_hold", 32'(count0), 3); ne += int'(exp0);
      end
      do_start();
      chk("pz_resume", 32'(count0), 3);
      chk("pz_resume_busy", 32'(busy0), 1);
      for (int i = 0; i < 3; i++) begin
         do_tick(); chk("pz_run", 32'(count0), 2 - i); ne += int'(exp0);
      end
      chk("pz_exp_pulses", 32'(ne), 1);
      chk("pz_done", 32'(done0), 1);

      // zero load then start
      do_load(0); do_start();
      chk("z_done0", 32'(done0), 1);
      chk("z_exp0", 32'(exp0), 1);
      chk("z_count0", 32'(count0), 0);
      chk("z_done1", 32'(done1), 1);
      chk("z_exp1", 32'(exp1), 1);
      do_idle();
      chk("z_exp0_once", 32'(exp0), 0);
      chk("z_exp1_once", 32'(exp1), 0);
      chk("z_count_hold", 32'(count0), 0);

      // reset mid-countdown, then load+start together
      do_ack();
      do_load(4); do_start(); do_tick(); do_tick();
      chk("rm_before", 32'(count0), 2);
      do_rst();
      chk("rm_count", 32'(count0), 0);
      chk("rm_busy", 32'(busy0), 0);
      chk("rm_exp", 32'(exp0), 0);
      chk("rm_exp1", 32'(exp1), 0);
      do_tick();
      chk("rm_tick_idle", 32'(count0), 0);
      load = 1; load_val = 16'd7; start = 1; cycle();
      chk("ls_count", 32'(count0), 7);
      chk("ls_busy", 32'(busy0), 0);
      do_idle();
      chk("ls_still_idle", 32'(busy0), 0);

      // start in DONE ignored, ack restores reload
      do_start();
      for (int i = 0; i < 7; i++) do_tick();
      chk("dn_done", 32'(done0), 1);
      do_start();
      chk("dn_start_done", 32'(done0), 1);
      chk("dn_start_busy", 32'(busy0), 0);
      chk("dn_start_count", 32'(count0), 0);
      do_ack();
      chk("dn_ack_done", 32'(done0), 0);
      chk("dn_ack_count", 32'(count0), 7);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 63) == 0);
         load     = ($urandom_range(0, 15) == 0);
         load_val = 16'($urandom_range(0, 5));
         stop     = ($urandom_range(0, 9) == 0);
         start    = ($urandom_range(0, 4) == 0);
         ack      = ($urandom_range(0, 7) == 0);
         tick     = ($urandom_range(0, 1) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 16, gives the bit width of the countdown value.
REQ-002 Parameter AUTO_RELOAD, default 0; 1 = periodic mode, 0 = one-shot mode.
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  one-cycle time-base pulse from the upstream modulo counter; one tick = one countdown unit.
REQ-006 load  input  1  captures load_val into the reload and count registers.
REQ-007 load_val  input  WIDTH  initial countdown value.
REQ-008 start  input  1  starts or resumes the countdown.
REQ-009 stop  input  1  pauses the countdown.
REQ-010 ack  input  1  clears done and returns the block to IDLE.
REQ-011 count  output  WIDTH  current remaining value, registered.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  level; high in DONE until ack, load or rst.
REQ-014 expired  output  1  one-cycle pulse on each expiry, including each period in periodic mode.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-016 Command priority per cycle SHALL be rst > load > stop > start > ack > tick.
REQ-017 load, in any state: reload <= load_val; count <= load_val; next state IDLE; done <= 0; tick is ignored that cycle.
REQ-018 IDLE + start: if count != 0, go to RUN; if count == 0, go to DONE with expired = 1 on the next cycle.
REQ-019 RUN + tick with count > 1: count <= count - 1.
REQ-020 RUN + tick with count == 1, AUTO_RELOAD = 0: count <= 0, go to DONE, expired = 1 in the same clock as count becomes 0.
REQ-021 RUN + tick with count == 1, AUTO_RELOAD = 1, reload != 0: count <= reload, stay in RUN, expired = 1.
REQ-022 RUN + tick with count == 1, AUTO_RELOAD = 1, reload == 0: same as REQ-020.
REQ-023 RUN + stop: go to PAUSE; count is frozen, and a simultaneous tick is discarded.
REQ-024 PAUSE + start: go to RUN; count is unchanged.
REQ-025 PAUSE + ack: go to IDLE; count is kept.
REQ-026 DONE + ack: go to IDLE, done <= 0, count <= reload.
REQ-027 DONE + start without ack: ignored.
REQ-028 tick outside RUN SHALL have no effect.
REQ-029 start while already in RUN SHALL have no effect.
REQ-030 count SHALL never wrap below 0; decrements use WIDTH-bit arithmetic with no borrow-out.
REQ-031 busy, done and expired SHALL be registered outputs with no combinational path from inputs.
REQ-032 Latency: a tick sampled in cycle N SHALL be reflected in count in cycle N+1.

Reset
REQ-033 On rst (synchronous, active-high), state = IDLE, count = 0, reload = 0, busy = 0, done = 0, expired = 0.
REQ-034 rst asserted mid-countdown SHALL abort the countdown with no expired pulse.
REQ-035 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-036 State encoding constants (IDLE, RUN, PAUSE, DONE) and the state type SHALL live in the shared package timer_pkg.
REQ-037 The block SHALL be a single module with no sub-module; the tick source sits outside the block.

Verification
REQ-038 WIDTH = 16, AUTO_RELOAD = 0; load 3, start, 3 ticks -> count goes 3,2,1,0; expired pulses once on the third tick; done = 1, busy = 0.
REQ-039 AUTO_RELOAD = 1; load 2, start, 6 ticks -> count goes 2,1,2,1,2,1,2; expired pulses 3 times; done stays 0.
REQ-040 load 5, start, 2 ticks, stop together with a tick, 3 ticks, start, 3 ticks -> count is held at 3 while paused, then reaches 0 with one expired pulse.
REQ-041 load 0, start -> next cycle done = 1 and expired = 1 for exactly one cycle; count stays 0.
REQ-042 load 4, start, 2 ticks, rst -> count = 0, state IDLE, no expired pulse; a following load together with start in the same cycle -> load wins and state is IDLE.
REQ-043 In DONE, apply start, then ack -> start is ignored; after ack, count = reload and done = 0.
